// File: rtl/usb_boot_sequencer.sv
// usb_boot_sequencer: wakes the SPI flash with a release-from-power-down command, then fires warm boot
module usb_boot_sequencer #(
   parameter int         CS_IDLE_CYCLES = 16,
   parameter int         SCK_DIV        = 4,
   parameter logic [7:0] WAKE_CMD       = 8'hAB,
   parameter int         TRES_CYCLES    = 240
) (
   input  logic       clk_48mhz,
   input  logic       reset_n,
   input  logic       boot_req,
   input  logic [1:0] image_sel,
   input  logic       bridge_spi_cs,
   input  logic       bridge_spi_sck,
   input  logic       bridge_spi_mosi,
   output logic       bridge_spi_miso,
   output logic       spi_cs,
   output logic       spi_sck,
   output logic       spi_mosi,
   input  logic       spi_miso,
   output logic       warmboot_boot,
   output logic [1:0] warmboot_s,
   output logic       busy
);
   typedef enum logic [2:0] {IDLE, WAIT_IDLE, CS_SETUP, SHIFT, CS_HOLD, TRES_WAIT, BOOT} state_t;
   state_t     state, nxt;
   logic [7:0] idle_cnt, sh;
   logic [9:0] cnt;
   logic [3:0] ph;
   logic [1:0] sel_q;
   logic       own_cs, own_sck, tick, pass;
   assign tick = cnt == 10'(SCK_DIV - 1);
   // state register
   always_ff @(posedge clk_48mhz or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= nxt;
   // next state: takeover after a quiet bridge, then fixed-length wake sequence, BOOT is terminal
   always_comb begin
      nxt = state;
      case (state)
         IDLE:      nxt = boot_req ? WAIT_IDLE : IDLE;
         WAIT_IDLE: nxt = (bridge_spi_cs && idle_cnt == 8'(CS_IDLE_CYCLES - 1)) ? CS_SETUP : WAIT_IDLE;
         CS_SETUP:  nxt = tick ? SHIFT : CS_SETUP;
         SHIFT:     nxt = (tick && ph == 4'd15) ? CS_HOLD : SHIFT;
         CS_HOLD:   nxt = tick ? TRES_WAIT : CS_HOLD;
         TRES_WAIT: nxt = (cnt == 10'(TRES_CYCLES - 1)) ? BOOT : TRES_WAIT;
         default:   nxt = BOOT;
      endcase
   end
   // counters, latched image select, registered owned-bus and warm-boot outputs
   always_ff @(posedge clk_48mhz or negedge reset_n)
      if (!reset_n) begin
         idle_cnt      <= '0;
         cnt           <= '0;
         ph            <= '0;
         sel_q         <= '0;
         own_cs        <= 1'b1;
         own_sck       <= 1'b0;
         sh            <= '0;
         warmboot_boot <= 1'b0;
         warmboot_s    <= '0;
      end else begin
         idle_cnt      <= (state == WAIT_IDLE && bridge_spi_cs) ? idle_cnt + {7'd0, ~&idle_cnt} : '0;
         cnt           <= (state != nxt || (state == SHIFT && tick)) ? '0 : cnt + 10'd1;
         ph            <= state != SHIFT ? '0 : ph + {3'd0, tick};
         sel_q         <= (state == IDLE && boot_req) ? image_sel : sel_q;
         own_cs        <= !(nxt inside {CS_SETUP, SHIFT, CS_HOLD});
         own_sck       <= nxt == SHIFT && (state != SHIFT || (own_sck ^ tick));
         sh            <= nxt == CS_SETUP ? WAKE_CMD : (state == SHIFT && tick && own_sck) ? {sh[6:0], 1'b0} : sh;
         warmboot_boot <= warmboot_boot | (nxt == BOOT);
         warmboot_s    <= nxt == BOOT ? sel_q : warmboot_s;
      end
   // bus mux: bridge owns the flash until takeover, then it is locked out
   always_comb begin
      pass            = state == IDLE || state == WAIT_IDLE;
      spi_cs          = pass ? bridge_spi_cs : own_cs;
      spi_sck         = pass ? bridge_spi_sck : own_sck;
      spi_mosi        = pass ? bridge_spi_mosi : sh[7];
      bridge_spi_miso = pass & spi_miso;
      busy            = state != IDLE;
   end
endmodule
